fft_frame_feeder: RTL

Producer end of the FFT core's sink interface. It buffers a continuous complex sample stream, for example from an ADC front end, in an internal FIFO. It then emits gap-free FRAME_LEN-point frames with sink_sop, sink_eop and sink_valid framing, honouring the core's sink_ready backpressure. It sits directly upstream of fft_control and drives its sink_* inputs.

---
 rtl/fft_pkg.sv | 9 +
 rtl/fft_frame_feeder_if.sv | 14 +
 rtl/fft_feed_fifo.sv | 56 +++++
 rtl/fft_frame_feeder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the FFT frame feeder.
package fft_pkg;
   localparam int FFT_DATA_W     = 8;
   localparam int FFT_FRAME_LEN  = 1024;
   localparam int FFT_FRAME_LOG2 = $clog2(FFT_FRAME_LEN);
   localparam int FFT_FIFO_DEPTH = 2048;

   typedef enum logic [1:0] {IDLE, ARM, SEND, DONE} feed_state_t;
endpackage

// File: rtl/fft_frame_feeder_if.sv
// Streaming sink bus into the FFT core: data plus sop/eop framing and ready backpressure.
interface fft_frame_feeder_if #(parameter int DATA_W = fft_pkg::FFT_DATA_W);
   logic [DATA_W-1:0] sink_real;
   logic [DATA_W-1:0] sink_imag;
   logic              sink_valid;
   logic              sink_sop;
   logic              sink_eop;
   logic              sink_ready;

   modport master (output sink_real, sink_imag, sink_valid, sink_sop, sink_eop,
                   input  sink_ready);
   modport slave  (input  sink_real, sink_imag, sink_valid, sink_sop, sink_eop,
                   output sink_ready);
endinterface

// File: rtl/fft_feed_fifo.sv
// Synchronous sample FIFO with registered read data and an occupancy level output.
module fft_feed_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 2048,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            rd_data <= mem[rd_ptr];
         end
         case ({do_wr, do_rd})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Storage is not reset; pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers a complex sample stream and emits gap-free FRAME_LEN-point frames to the FFT core.
//   state | meaning
//   IDLE  | emission disabled; samples still buffered; overflow clearable
//   ARM   | enabled, waiting for a full frame's worth of samples
//   SEND  | streaming one frame, beats issued from the FIFO
//   DONE  | one-cycle frame wrap-up, counters rearmed
module fft_frame_feeder
   import fft_pkg::*;
#(
   parameter int DATA_W     = FFT_DATA_W,
   parameter int FRAME_LEN  = FFT_FRAME_LEN,
   parameter int FIFO_DEPTH = FFT_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [DATA_W-1:0]    in_real,
   input  logic [DATA_W-1:0]    in_imag,
   input  logic                 in_valid,
   fft_frame_feeder_if.master   sink,
   output logic                 overflow,
   output logic [15:0]          frame_cnt,
   output logic                 busy
);
   localparam int LW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] LAST_BEAT = LW'(FRAME_LEN - 1);
   localparam logic [LW-1:0] BEAT_ONE  = LW'(1);
   localparam logic [AW:0]   FRAME_LVL = (AW+1)'(FRAME_LEN);

   feed_state_t         state;
   logic [LW-1:0]       beat;
   logic                all_issued;
   logic                rd_vld;
   logic                rd_first;
   logic                rd_last;
   logic [2*DATA_W-1:0] rd_data;
   logic                fifo_full;
   logic                fifo_empty;
   logic [AW:0]         level;
   logic                load_ok;
   logic                start;
   logic                rd_en;
   logic                eop_xfer;

   fft_feed_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (in_valid),
      .wr_data ({in_real, in_imag}),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   // The first read is issued on the ARM->SEND edge so sop lands two edges after the fill.
   assign load_ok  = !sink.sink_valid || sink.sink_ready;
   assign start    = (state == ARM) && enable && (level >= FRAME_LVL);
   assign rd_en    = load_ok && (start || ((state == SEND) && !all_issued));
   assign eop_xfer = sink.sink_valid && sink.sink_ready && sink.sink_eop;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         beat            <= '0;
         all_issued      <= 1'b0;
         rd_vld          <= 1'b0;
         rd_first        <= 1'b0;
         rd_last         <= 1'b0;
         sink.sink_real  <= '0;
         sink.sink_imag  <= '0;
         sink.sink_valid <= 1'b0;
         sink.sink_sop   <= 1'b0;
         sink.sink_eop   <= 1'b0;
         overflow        <= 1'b0;
         frame_cnt       <= '0;
         busy            <= 1'b0;
      end else begin
         if (in_valid && fifo_full)          overflow <= 1'b1;
         else if (state == IDLE && !enable)  overflow <= 1'b0;

         // rd_vld marks the FIFO read register as holding a beat not yet in sink_*.
         if (rd_en) begin
            rd_vld   <= 1'b1;
            rd_first <= (beat == '0);
            rd_last  <= (beat == LAST_BEAT);
            beat     <= beat + BEAT_ONE;
            if (beat == LAST_BEAT) all_issued <= 1'b1;
         end else if (load_ok) begin
            rd_vld <= 1'b0;
         end

         if (load_ok) begin
            sink.sink_valid <= rd_vld;
            sink.sink_sop   <= rd_vld && rd_first;
            sink.sink_eop   <= rd_vld && rd_last;
            if (rd_vld) {sink.sink_real, sink.sink_imag} <= rd_data;
         end

         case (state)
            IDLE: if (enable) begin
               state <= ARM;
               busy  <= 1'b1;
            end
            ARM: if (!enable) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (start) begin
               state <= SEND;
            end
            SEND: if (eop_xfer) begin
               state     <= DONE;
               frame_cnt <= frame_cnt + 16'd1;
            end
            DONE: begin
               beat       <= '0;
               all_issued <= 1'b0;
               state      <= enable ? ARM : IDLE;
               busy       <= enable;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
